// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for common-anode 7-segment digits with double-buffered
// display data, leading-zero suppression and per-digit blank/decimal-point masks.
module seg7_scan_driver #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CLK_DIV        = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    localparam int unsigned IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_suppress,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);

    logic [PRE_W-1:0]    presc_q;
    logic [IDX_W-1:0]    idx_q;
    logic [4*DIGITS-1:0] pend_value_q, act_value_q;
    logic [DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [DIGITS-1:0]   pend_blank_q, act_blank_q;
    logic                pend_valid_q;
    logic                frame_done_q;
    logic [6:0]          seg_q;
    logic                dp_q;
    logic [DIGITS-1:0]   an_q;

    logic                tc;
    logic                wrap;
    logic [3:0]          nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_lz;
    logic                zero_run;
    logic [DIGITS-1:0]   an_lit;
    logic [6:0]          seg_lit;
    logic                dp_lit;

    // Returns the active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0000011;
            4'hC:    decode = 7'b0100111;
            4'hD:    decode = 7'b0100001;
            4'hE:    decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign tc   = en && (presc_q == PRE_W'(CLK_DIV - 1));
    assign wrap = tc && (idx_q == IDX_W'(DIGITS - 1));

    // Walk from the most significant digit down so zero_run tells whether
    // every nibble from digit i upward is zero.
    always_comb begin
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        zero_run  = 1'b1;
        an_lit    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run  = zero_run && (act_value_q[4*i +: 4] == 4'h0);
            an_lit[i] = (idx_q == IDX_W'(i));
            if (idx_q == IDX_W'(i)) begin
                nib       = act_value_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = act_blank_q[i];
                cur_lz    = lz_suppress && zero_run && (i != 0);
            end
        end
        seg_lit = (cur_blank || cur_lz) ? 7'b0000000 : ~decode(nib);
        dp_lit  = cur_dp && !cur_blank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= {7{SEG_ACTIVE_LOW}};
            dp_q         <= SEG_ACTIVE_LOW;
            an_q         <= {DIGITS{AN_ACTIVE_LOW}};
        end else begin
            if (en) begin
                if (tc) begin
                    presc_q <= '0;
                    idx_q   <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
            frame_done_q <= wrap;

            // A load coinciding with the wrap bypasses the pending buffer.
            if (load && wrap) begin
                act_value_q  <= value;
                act_dp_q     <= dp;
                act_blank_q  <= blank;
                pend_valid_q <= 1'b0;
            end else begin
                if (load) begin
                    pend_value_q <= value;
                    pend_dp_q    <= dp;
                    pend_blank_q <= blank;
                    pend_valid_q <= 1'b1;
                end
                if (wrap && pend_valid_q) begin
                    act_value_q  <= pend_value_q;
                    act_dp_q     <= pend_dp_q;
                    act_blank_q  <= pend_blank_q;
                    pend_valid_q <= 1'b0;
                end
            end

            seg_q <= (en ? seg_lit : 7'b0000000) ^ {7{SEG_ACTIVE_LOW}};
            dp_q  <= (en && dp_lit) ^ SEG_ACTIVE_LOW;
            an_q  <= (en ? an_lit : {DIGITS{1'b0}}) ^ {DIGITS{AN_ACTIVE_LOW}};
        end
    end

    assign seg        = seg_q;
    assign dp_out     = dp_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a bank of common-anode 7-segment digits. It accepts a packed hex value plus per-digit decimal-point and blank masks. It scans one digit at a time at a programmable rate, decoding each nibble to segment patterns. Display data is double-buffered so a new value is applied only at a frame boundary, which prevents tearing. It sits between datapath/counter logic and the board's segment/anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
CLK_DIV, 50000, clk cycles each digit is lit (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment/dp outputs low-true; 0 = high-true
AN_ACTIVE_LOW, 1, 1 = anode selects low-true; 0 = high-true

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  scan enable; low = display dark, scan frozen
load  input  1  one-cycle strobe: capture value/dp/blank into pending buffer
value  input  4*DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 = rightmost
dp  input  DIGITS  decimal point request per digit
blank  input  DIGITS  force digit i dark (overrides everything)
lz_suppress  input  1  blank leading zero digits (digit 0 never suppressed)
seg  output  7  segment drive {g,f,e,d,c,b,a}
dp_out  output  1  decimal point drive
an  output  DIGITS  one-hot anode select
digit_idx  output  ceil(log2(DIGITS)), min 1  index of currently lit digit
frame_done  output  1  one-cycle pulse when scan wraps from DIGITS-1 to 0

Behaviour:
- Reset (async, immediate): prescaler=0, digit_idx=0, pending and active buffers=0, pending_valid=0, frame_done=0; an all inactive, seg and dp_out all off (level per polarity params).
- Prescaler counts 0..CLK_DIV-1 while en=1. At terminal count it returns to 0 and digit_idx advances (DIGITS-1 wraps to 0). On the wrap, frame_done=1 for exactly that one cycle.
- Buffering: load=1 copies value/dp/blank into pending and sets pending_valid. Multiple loads before a boundary: last wins. On a wrap cycle with pending_valid=1, pending copies to active and pending_valid clears. load and wrap in the same cycle: the input values go straight to active and pending_valid stays 0. lz_suppress is sampled live, not buffered.
- Decode (active-low form; inverted when SEG_ACTIVE_LOW=0): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 c=0100111 d=0100001 E=0000110 F=0001110.
- Leading-zero: when lz_suppress=1, digit i>0 is dark if active nibbles i..DIGITS-1 are all 0. A dark digit still lights its dp if dp[i]=1 and blank[i]=0.
- blank[i]=1: seg and dp_out fully off for digit i; its anode is still driven (timing stays uniform).
- Outputs are registered: seg/dp_out/an reflect digit_idx with exactly 1 cycle latency. Anode is one-hot at the registered index.
- en=0: prescaler and digit_idx hold; an inactive and seg/dp off from the next cycle; load still works; no frame_done. Re-enable resumes at the held index and count.
- DIGITS=1: index stays 0; frame_done pulses every CLK_DIV cycles.

Test Plan:
- Reset mid-scan (DIGITS=4, CLK_DIV=4, idx=2): assert rst -> an=1111, seg=1111111, dp_out=1, digit_idx=0 immediately. Release -> digit 0 lit after 1 cycle.
- Decode sweep: load value=16'hFEDC, then 16'hBA98, 16'h7654, 16'h3210 -> each digit's seg matches the table for all 16 codes; an walks 1110,1101,1011,0111, 4 cycles each.
- Buffering: load 16'h1234 mid-frame -> display stays 16'h0000 until wrap. frame_done pulses once per 16 cycles. A second load before the wrap (16'h5678) -> 5678 shown; 1234 is never displayed.
- Load on the wrap cycle with 16'hABCD -> A,B,C,D visible in the immediately following frame.
- Leading zero: value=16'h0040, lz_suppress=1 -> digits 3,2 dark, digit 1 shows 4 (0011001), digit 0 shows 0. Add dp=4'b1000 -> digit 3 shows only dp. Value 0 -> only digit 0 shows 0.
- blank=4'b0010 with dp=4'b0010 -> digit 1 fully off while an=1101. en low for 10 cycles -> an=1111, idx frozen, no frame_done; resume at the same index.
